// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the register interface and uart_core's transmitter.
// Define UART_TX_FIFO_OVF_EN to add the sticky overflow flag (ports ovf_clr/overflow).
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  input  logic          tx_done,
  output logic          idle
`ifdef UART_TX_FIFO_OVF_EN
  ,
  input  logic          ovf_clr,
  output logic          overflow
`endif
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic [AW:0]   level_d;
  logic          push;
  logic          pop;

  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign tx_valid = ~empty;
  assign tx_data  = mem[rd_ptr];
  assign idle     = empty & tx_ready;

  // Both strobes are qualified by the pre-edge full/empty, so a write at
  // full is dropped even when a pop frees a slot on the same edge.
  assign push = wr_en & ~full & ~flush;
  assign pop  = tx_done & ~empty & ~flush;

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      level_q <= level_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

`ifdef UART_TX_FIFO_OVF_EN
  // Set wins over ovf_clr so a drop on the clearing edge is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              overflow <= 1'b0;
    else if (flush)         overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
    else if (ovf_clr)       overflow <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized self-checking bench for uart_tx_fifo against a queue model,
// with a behavioural uart_core loopback.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          wr_en    = 1'b0;
  logic [7:0]    wr_data  = '0;
  logic          flush    = 1'b0;
  logic          tx_ready = 1'b1;
  logic          tx_done  = 1'b0;
  logic          ovf_clr  = 1'b0;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          idle;
`ifdef UART_TX_FIFO_OVF_EN
  logic          overflow;
`endif

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx_done  (tx_done),
    .idle     (idle)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .ovf_clr  (ovf_clr),
    .overflow (overflow)
`endif
  );

  logic [7:0] mq[$];
  bit         movf;
  int         checks;
  int         errors;
  int         accepted;

  bit         core_en;
  bit         core_busy;
  int         core_cnt;
  logic [7:0] core_byte;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("level", 32'(level), 32'(mq.size()));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    check("tx_valid", 32'(tx_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) check("tx_data", 32'(tx_data), 32'(mq[0]));
    check("idle", 32'(idle), 32'(mq.size() == 0 && tx_ready));
`ifdef UART_TX_FIFO_OVF_EN
    check("overflow", 32'(overflow), 32'(movf));
`endif
  endtask

  // One clock: drive inputs, advance the model by the FIFO rules, compare,
  // then let the uart_core model react to what the DUT now offers.
  task automatic cycle(input logic w, input logic [7:0] d, input logic f, input logic clr);
    bit         was_full;
    bit         was_empty;
    logic [7:0] popped;
    wr_en = w; wr_data = d; flush = f; ovf_clr = clr;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    @(posedge clk); #1;
    if (f) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      if (tx_done && !was_empty) begin
        popped = mq.pop_front();
        if (core_en) check("rx_data", 32'(core_byte), 32'(popped));
      end
      if (w && !was_full) begin
        mq.push_back(d);
        accepted++;
      end
      if (w && was_full) movf = 1'b1;
      else if (clr)      movf = 1'b0;
    end
    wr_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
    compare_all();
    if (core_en) begin
      if (tx_done) core_busy = 1'b0;
      else if (core_busy && core_cnt > 0) core_cnt--;
      if (!core_busy && tx_valid) begin
        core_busy = 1'b1;
        core_byte = tx_data;
        core_cnt  = int'($urandom_range(1, 4));
      end
      tx_ready = !core_busy;
      tx_done  = core_busy && core_cnt == 0;
    end
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; accepted = 0;
    core_en = 1'b0; core_busy = 1'b0; core_cnt = 0; core_byte = '0; movf = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 compare_all();
    #2 reset = 1'b0;

    // Single byte through and out
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    check("first_data", 32'(tx_data), 32'h55);
    tx_done = 1'b1; cycle(1'b0, 8'h00, 1'b0, 1'b0); tx_done = 1'b0;
    tx_ready = 1'b0; #1;
    check("idle_busy", 32'(idle), 32'(mq.size() == 0 && tx_ready));
    tx_ready = 1'b1; #1;
    check("idle_ready", 32'(idle), 32'(mq.size() == 0 && tx_ready));

    // Fill, overflow, clear behaviour, ordered drain
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b1, 8'hAB, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", 32'(tx_data), 32'(i));
      tx_done = 1'b1; cycle(1'b0, 8'h00, 1'b0, 1'b0);
      tx_done = 1'b0; cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end

    // Drop at full while popping; push+pop at level 5
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    tx_done = 1'b1; cycle(1'b1, 8'hBB, 1'b0, 1'b0); tx_done = 1'b0;
    check("drop_pop_level", 32'(level), 32'(DEPTH - 1));
    tx_done = 1'b1;
    while (mq.size() > 5) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    tx_done = 1'b0;
    check("pushpop_level", 32'(level), 32'd5);

    // Flush at level 7 with a concurrent write
    cycle(1'b1, 8'h71, 1'b0, 1'b0);
    cycle(1'b1, 8'h72, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    check("flush_valid", 32'(tx_valid), 32'(mq.size() != 0));

    // Flush clears a set overflow
    for (int i = 0; i <= DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset between edges, mid-transfer with overflow set
    for (int i = 0; i <= DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    #3 reset = 1'b1;
    mq.delete(); movf = 1'b0;
    #1 compare_all();
    #1 reset = 1'b0;
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    check("post_reset_data", 32'(tx_data), 32'h3C);

    // Random loopback through the uart_core model
    core_en = 1'b1; tx_ready = 1'b1; tx_done = 1'b0; accepted = 0;
    n = 0;
    while ((accepted < 40 || mq.size() != 0 || core_busy) && n < 3000) begin
      cycle(accepted < 40 && $urandom_range(0, 3) != 0, 8'($urandom), 1'b0,
            $urandom_range(0, 7) == 0);
      n++;
    end
    check("loop_drained", 32'(mq.size()), 32'd0);
    check("loop_accepted", 32'(accepted), 32'd40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of byte entries (power of two, 2..256).
REQ-002 SHALL have parameter AW, default 4, pointer width; DEPTH = 2**AW.
REQ-003 SHALL have port clk  input  1  single clock; all state advances on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  write strobe from the register interface.
REQ-006 SHALL have port wr_data  input  8  byte to enqueue.
REQ-007 SHALL have port flush  input  1  synchronous clear of all entries.
REQ-008 SHALL have port full  output  1  no free entry.
REQ-009 SHALL have port empty  output  1  no stored entry.
REQ-010 SHALL have port level  output  AW+1  stored entry count, 0..DEPTH.
REQ-011 SHALL have port tx_valid  output  1  to uart_core tx_valid; head byte is offered.
REQ-012 SHALL have port tx_data  output  8  to uart_core tx_data; head byte.
REQ-013 SHALL have port tx_ready  input  1  from uart_core; transmitter idle.
REQ-014 SHALL have port tx_done  input  1  from uart_core; one-cycle pulse when a byte finishes.
REQ-015 SHALL have port idle  output  1  empty AND tx_ready.

Function
REQ-016 Push SHALL occur on a rising edge with wr_en=1 AND full=0 AND flush=0; wr_data is stored at the write pointer, which then increments modulo DEPTH.
REQ-017 wr_en while full=1 SHALL be dropped with no state change, including when tx_done is simultaneously high.
REQ-018 tx_valid SHALL equal NOT empty; a push into an empty FIFO at edge N SHALL make tx_valid=1 after edge N.
REQ-019 tx_data SHALL present the entry at the read pointer and SHALL remain stable while tx_valid=1 until a pop.
REQ-020 Pop SHALL occur on a rising edge with tx_done=1 AND empty=0 AND flush=0; the read pointer then increments modulo DEPTH.
REQ-021 tx_done while empty=1 SHALL be ignored.
REQ-022 Simultaneous push and pop SHALL leave level unchanged and advance both pointers.
REQ-023 level SHALL be +1 on push-only, -1 on pop-only, and otherwise unchanged; full = (level==DEPTH); empty = (level==0).
REQ-024 flush=1 SHALL zero both pointers and level at the next edge, overriding push, pop and the overflow flag update; tx_valid SHALL drop after that edge.
REQ-025 Pointers SHALL wrap from DEPTH-1 to 0 without data corruption.

Reset
REQ-026 reset=1 SHALL immediately, without waiting for clk, clear pointers and level, giving empty=1, full=0, level=0 and tx_valid=0.
REQ-027 Storage contents are not reset; tx_data is don't-care while tx_valid=0.
REQ-028 Reset asserted mid-transfer SHALL discard all entries; the first push after deassertion SHALL appear at tx_data.

Configuration
REQ-029 Macro UART_TX_FIFO_OVF_EN, when defined, SHALL add port ovf_clr (input, 1) and port overflow (output, 1).
REQ-030 With the macro defined, overflow SHALL be a sticky flag set by a dropped write (wr_en=1 while full=1), cleared by ovf_clr=1, by flush or by reset; a drop coincident with ovf_clr SHALL leave overflow=1.
REQ-031 Without the macro, neither port SHALL exist, and dropped writes SHALL be silently discarded.

Verification
REQ-032 Reset, then push 0x55 -> tx_valid=1 and tx_data=0x55 one edge later, level=1; tx_done pulse -> empty=1 and idle follows tx_ready.
REQ-033 Push 16 bytes 0x00..0x0F (DEPTH=16), then push 0xAA -> full=1, level=16, 0xAA dropped (overflow=1 with the macro); drain via uart_core -> bytes 0x00..0x0F in order.
REQ-034 At level=16, assert wr_en=0xBB and tx_done on the same edge -> write dropped and level=15; at level=5, push and pop together -> level stays 5.
REQ-035 Loop 40 random bytes through the FIFO and uart_core with a loopback to rx -> every rx_data matches in order, pointers wrap at least twice.
REQ-036 At level=7, assert flush together with wr_en -> level=0, tx_valid=0; asserting reset between clock edges -> empty=1 before the next edge.
